column_buffer: RTL
==================

# column_buffer

Double-buffered per-column store that feeds the GPU's `distance` and `texture` inputs. The CPU writes the next frame's ray-cast results into the back bank while the GPU reads the front bank through `reading_index`. A CPU-requested swap takes effect only at the start of vertical sync, so a frame never shows a mix of two scenes. It sits between the CPU's memory-mapped I/O decode and the GPU.

## Interface
- `COLUMNS`, 320, number of screen columns per bank
- `FAR_DISTANCE`, 16'hFFFF, distance returned for out-of-range indices and written by hardware clear
- `clk`  in  1  system clock
- `clr`  in  1  asynchronous, active-low reset
- `cpu_we`  in  1  write strobe, one word per cycle
- `cpu_addr`  in  10  bit 9 selects the array: 0 = distance, 1 = texture; bits [8:0] = column
- `cpu_wdata`  in  16  write data
- `cpu_rdata`  out  16  back-bank readback of `cpu_addr`
- `cpu_swap_req`  in  1  single-cycle pulse requesting a bank swap
- `swap_pending`  out  1  a swap is requested but not yet taken
- `swap_done`  out  1  one-cycle pulse on the cycle the swap occurs
- `busy`  out  1  back bank unavailable (hardware clear running)
- `front_bank`  out  1  index of the bank currently displayed
- `v_sync`  in  1  VGA vertical sync from the GPU, active-low
- `reading_index`  in  9  column requested by the GPU
- `distance`  out  16  front-bank distance for `reading_index`
- `texture`  out  16  front-bank texture word for `reading_index`

## Operation
- Storage: two banks, each holding `COLUMNS` distance words and `COLUMNS` texture words. Memory contents are not reset.
- CPU write:
  - When `cpu_we=1`, `busy=0` and column < `COLUMNS`, the word is written to bank `~front_bank`, in the array selected by `cpu_addr[9]`.
  - Writes are dropped when the column is ≥ `COLUMNS` or `busy=1`.
- CPU read: `cpu_rdata` is registered with 1-cycle latency from the back bank. An out-of-range column reads 0.
- GPU read:
  - `distance` and `texture` are registered with 1-cycle latency from the front bank.
  - If `reading_index` ≥ `COLUMNS`, `distance=FAR_DISTANCE` and `texture=0`.
- Swap control states:
  - IDLE: on `cpu_swap_req`, go to PENDING and set `swap_pending=1`.
  - PENDING: on a falling edge of `v_sync`, toggle `front_bank`, pulse `swap_done`, clear `swap_pending`, and go to IDLE (or CLEAR when enabled).
  - CLEAR: only exists when clear is compiled in; see Configuration.
- Edge detect: `v_sync` is registered once and a fall is `prev & ~v_sync`. The input is already in the `clk` domain, so there is no synchroniser.
- Boundary conditions:
  - `cpu_swap_req` coinciding with a `v_sync` fall while in IDLE: the request is accepted and the swap happens on that same edge.
  - Extra `cpu_swap_req` pulses while PENDING are absorbed; a single swap occurs.
  - `cpu_swap_req` while CLEAR: the request is latched and `swap_pending=1`; the state goes to PENDING when the clear finishes.
  - A write on the same cycle as the swap edge goes to the pre-swap back bank, i.e. `front_bank` as sampled that cycle.

## Timing
- Reset values:
  - `front_bank=0`, `swap_pending=0`, `swap_done=0`, `busy=0`
  - `cpu_rdata=0`, `distance=FAR_DISTANCE`, `texture=0`
  - State IDLE, `v_sync` history register = 1
- `front_bank` changes on the clock edge after the sampled `v_sync` fall. `distance` and `texture` reflect the new bank one cycle later.
- The GPU holds `reading_index` for 4 `clk` cycles (pixel enable), so the 1-cycle read latency is absorbed.
- Reset asserted mid-clear or mid-pending returns all state to IDLE immediately.

## Configuration
- `COLUMN_BUFFER_CLEAR_EN` defined:
  - After each swap, the block enters CLEAR with `busy=1`.
  - A 9-bit counter sweeps columns 0..`COLUMNS`-1 of the new back bank, one per cycle, writing `FAR_DISTANCE` and texture 0.
  - After the last column, `busy=0` and the state returns to IDLE, or PENDING if a request was latched. Total `COLUMNS` cycles.
- Not defined: no CLEAR state and no counter; `busy` is tied 0. The back bank keeps the contents of two frames ago.

## Test plan
- Reset then idle: `reading_index=5` → `distance=16'hFFFF`, `texture=0` before any swap (bank 0 uninitialised is acceptable only after reset; the output register holds its reset value until the first read).
- Write and display:
  - Write distance `0x0123` to column 7 and texture `0x0215` (addr `0x207`), then pulse swap and drive a `v_sync` fall.
  - Response: `swap_done` pulses once, `front_bank=1`, and `reading_index=7` gives `distance=0x0123` and `texture=0x0215` after 1 cycle.
- Tear-free swap: `cpu_swap_req` 1000 cycles before the `v_sync` fall → `front_bank` unchanged and `swap_pending=1` until the edge, then toggles.
- Out of range:
  - Write to column 400 is dropped; readback of 400 is 0.
  - `reading_index=330` → `distance=16'hFFFF`, `texture=0`.
- Simultaneous: swap pulse, write to column 3 and `v_sync` fall on the same cycle → swap occurs, and the write lands in the now-front bank, readable by the GPU.
- With `COLUMN_BUFFER_CLEAR_EN`:
  - After a swap, `busy=1` for exactly 320 cycles and writes in that window are dropped.
  - Afterwards, back-bank readback of columns 0 and 319 returns `0xFFFF` (distance) and 0 (texture).

Source files
------------

// File: rtl/column_buffer.sv
// column_buffer: double-buffered per-column distance/texture store between
// the CPU's memory-mapped writes and the GPU's column reads. The CPU fills the
// back bank while the GPU reads the front bank. A requested swap waits for the
// next falling edge of v_sync so that a frame never mixes two scenes.
// Optional feature: define COLUMN_BUFFER_CLEAR_EN to sweep the new back bank
// to FAR_DISTANCE / texture 0 after every swap (busy=1 while it runs).
module column_buffer #(
    parameter int unsigned COLUMNS      = 320,
    parameter logic [15:0] FAR_DISTANCE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        cpu_we,
    input  logic [9:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    input  logic        cpu_swap_req,
    output logic        swap_pending,
    output logic        swap_done,
    output logic        busy,
    output logic        front_bank,
    input  logic        v_sync,
    input  logic [8:0]  reading_index,
    output logic [15:0] distance,
    output logic [15:0] texture
);

    localparam logic [8:0] LAST_COL = 9'(COLUMNS - 1);

`ifdef COLUMN_BUFFER_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic        vs_prev;
    logic        vs_fall;
    logic        do_swap;
    logic        fb_next;
    logic        done_next;
    logic        back_bank;
    logic [8:0]  cpu_col;
    logic        cpu_col_ok;
    logic        cpu_wr;
    logic        gpu_col_ok;

`ifdef COLUMN_BUFFER_CLEAR_EN
    logic [8:0]  clr_cnt;
    logic [8:0]  cnt_next;
    logic        req_latched;
    logic        latch_next;
`endif

    logic [15:0] dist_mem [2][COLUMNS];
    logic [15:0] tex_mem  [2][COLUMNS];

    // Address decode and write qualification shared by the memory and read paths.
    always_comb begin
        back_bank  = ~front_bank;
        cpu_col    = cpu_addr[8:0];
        cpu_col_ok = (cpu_col <= LAST_COL);
        cpu_wr     = cpu_we & ~busy & cpu_col_ok;
        gpu_col_ok = (reading_index <= LAST_COL);
    end

    // Swap control: next state, bank toggle and status outputs.
    always_comb begin
        state_next   = state;
        fb_next      = front_bank;
        done_next    = 1'b0;
        vs_fall      = vs_prev & ~v_sync;
        do_swap      = vs_fall & (((state == IDLE) & cpu_swap_req) | (state == PENDING));
`ifdef COLUMN_BUFFER_CLEAR_EN
        cnt_next     = clr_cnt;
        latch_next   = req_latched;
        busy         = (state == CLEAR);
        swap_pending = (state == PENDING) | req_latched;
`else
        busy         = 1'b0;
        swap_pending = (state == PENDING);
`endif

        case (state)
            IDLE: begin
                if (cpu_swap_req) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                state_next = PENDING;
            end
`ifdef COLUMN_BUFFER_CLEAR_EN
            CLEAR: begin
                // Requests arriving mid-clear are held until the sweep ends.
                if (cpu_swap_req) begin
                    latch_next = 1'b1;
                end
                cnt_next = clr_cnt + 9'd1;
                if (clr_cnt == LAST_COL) begin
                    cnt_next   = '0;
                    latch_next = 1'b0;
                    state_next = (req_latched | cpu_swap_req) ? PENDING : IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        if (do_swap) begin
            fb_next   = ~front_bank;
            done_next = 1'b1;
`ifdef COLUMN_BUFFER_CLEAR_EN
            state_next = CLEAR;
            cnt_next   = '0;
`else
            state_next = IDLE;
`endif
        end
    end

    // Control registers; reset returns the swap machine to IDLE immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            front_bank  <= 1'b0;
            swap_done   <= 1'b0;
            vs_prev     <= 1'b1;
`ifdef COLUMN_BUFFER_CLEAR_EN
            clr_cnt     <= '0;
            req_latched <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            front_bank  <= fb_next;
            swap_done   <= done_next;
            vs_prev     <= v_sync;
`ifdef COLUMN_BUFFER_CLEAR_EN
            clr_cnt     <= cnt_next;
            req_latched <= latch_next;
`endif
        end
    end

    // Back-bank writes from the CPU or the hardware clear; contents are not reset.
    always_ff @(posedge clk) begin
`ifdef COLUMN_BUFFER_CLEAR_EN
        if (state == CLEAR) begin
            dist_mem[back_bank][clr_cnt] <= FAR_DISTANCE;
            tex_mem[back_bank][clr_cnt]  <= '0;
        end else if (cpu_wr) begin
`else
        if (cpu_wr) begin
`endif
            if (cpu_addr[9]) begin
                tex_mem[back_bank][cpu_col] <= cpu_wdata;
            end else begin
                dist_mem[back_bank][cpu_col] <= cpu_wdata;
            end
        end
    end

    // Registered CPU readback of the back bank and GPU read of the front bank.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cpu_rdata <= '0;
            distance  <= FAR_DISTANCE;
            texture   <= '0;
        end else begin
            if (!cpu_col_ok) begin
                cpu_rdata <= '0;
            end else if (cpu_addr[9]) begin
                cpu_rdata <= tex_mem[back_bank][cpu_col];
            end else begin
                cpu_rdata <= dist_mem[back_bank][cpu_col];
            end

            if (gpu_col_ok) begin
                distance <= dist_mem[front_bank][reading_index];
                texture  <= tex_mem[front_bank][reading_index];
            end else begin
                distance <= FAR_DISTANCE;
                texture  <= '0;
            end
        end
    end

endmodule
